// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, opcode/funct constants, decoded bundle and decode function.
// ALU_DEC_MULDIV_EN enables decoding of mult/div; otherwise they decode as illegal.
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_ADDU = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_NOR  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_MULT = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_SRA  = 4'd12,
        ALU_OR   = 4'd13,
        ALU_LUI  = 4'd14,
        ALU_INV  = 4'd15
    } alu_ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        alu_ctrl_t        control;
        logic             a_sel;
        logic             b_sel;
        logic [XLEN-1:0]  imm_ext;
        logic [4:0]       rs_idx;
        logic [4:0]       rt_idx;
        logic [4:0]       dst_idx;
        logic             reg_write;
        logic             illegal;
    } alu_dec_t;

    function automatic alu_dec_t alu_decode(input logic [XLEN-1:0] instr);
        alu_dec_t d;
        logic [5:0] op;
        logic [5:0] fn;
        op = instr[31:26];
        fn = instr[5:0];
        d = '0;
        d.control = ALU_INV;
        d.illegal = 1'b1;
        d.rs_idx = instr[25:21];
        d.rt_idx = instr[20:16];
        d.dst_idx = instr[15:11];
        d.imm_ext = {{(XLEN-16){instr[15]}}, instr[15:0]};
        if (op == OP_RTYPE) begin
            d.illegal = 1'b0;
            d.reg_write = 1'b1;
            case (fn)
                FN_ADD:  d.control = ALU_ADD;
                FN_SUB:  d.control = ALU_SUB;
                FN_ADDU: d.control = ALU_ADDU;
                FN_SUBU: d.control = ALU_SUBU;
                FN_AND:  d.control = ALU_AND;
                FN_OR:   d.control = ALU_OR;
                FN_XOR:  d.control = ALU_XOR;
                FN_NOR:  d.control = ALU_NOR;
                FN_SLT:  d.control = ALU_SLT;
                FN_SLL:  begin d.control = ALU_SLL; d.a_sel = 1'b1; end
                FN_SRL:  begin d.control = ALU_SRL; d.a_sel = 1'b1; end
                FN_SRA:  begin d.control = ALU_SRA; d.a_sel = 1'b1; end
                FN_SLLV: d.control = ALU_SLL;
                FN_SRLV: d.control = ALU_SRL;
                FN_SRAV: d.control = ALU_SRA;
`ifdef ALU_DEC_MULDIV_EN
                FN_MULT: begin d.control = ALU_MULT; d.reg_write = 1'b0; end
                FN_DIV:  begin d.control = ALU_DIV; d.reg_write = 1'b0; end
`endif
                default: begin d.illegal = 1'b1; d.reg_write = 1'b0; end
            endcase
        end else begin
            d.illegal = 1'b0;
            d.reg_write = 1'b1;
            d.b_sel = 1'b1;
            d.dst_idx = instr[20:16];
            case (op)
                OP_ADDI:  d.control = ALU_ADD;
                OP_ADDIU: d.control = ALU_ADDU;
                OP_SLTI:  d.control = ALU_SLT;
                OP_LW:    d.control = ALU_ADDU;
                OP_SW:    begin d.control = ALU_ADDU; d.reg_write = 1'b0; end
                OP_ANDI:  begin d.control = ALU_AND; d.imm_ext = {{(XLEN-16){1'b0}}, instr[15:0]}; end
                OP_ORI:   begin d.control = ALU_OR; d.imm_ext = {{(XLEN-16){1'b0}}, instr[15:0]}; end
                OP_XORI:  begin d.control = ALU_XOR; d.imm_ext = {{(XLEN-16){1'b0}}, instr[15:0]}; end
                OP_LUI:   begin d.control = ALU_LUI; d.imm_ext = {{(XLEN-16){1'b0}}, instr[15:0]}; end
                OP_BEQ, OP_BNE: begin d.control = ALU_SUB; d.b_sel = 1'b0; d.reg_write = 1'b0; end
                default:  begin d.illegal = 1'b1; d.reg_write = 1'b0; d.b_sel = 1'b0; end
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: registered valid/ready stage with one skid entry; in_ready depends only on state.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         in_fire;
    logic         load_main;

    assign in_ready  = ~skid_valid;
    assign in_fire   = in_valid & in_ready;
    assign load_main = ~out_valid | out_ready;

    // skid entry always has priority into main so ordering is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (load_main) begin
            out_valid  <= skid_valid | in_fire;
            if (skid_valid)
                out_data <= skid_data;
            else if (in_fire)
                out_data <= in_data;
            skid_valid <= 1'b0;
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: decodes MIPS words into ALU control bundles behind a skid buffer.
// ALU_DEC_MULDIV_EN (in alu_pkg) enables mult/div decode.
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int CONTROL_LENGTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LENGTH-1:0]         instr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CONTROL_LENGTH-1:0] control,
    output logic                      a_sel,
    output logic                      b_sel,
    output logic [LENGTH-1:0]         imm_ext,
    output logic [4:0]                rs_idx,
    output logic [4:0]                rt_idx,
    output logic [4:0]                dst_idx,
    output logic                      reg_write,
    output logic                      illegal,
    output logic [7:0]                illegal_count
);

    alu_dec_t dec;
    alu_dec_t q;

    assign dec = alu_decode(instr);

    skid_buffer #(.W($bits(alu_dec_t))) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (q)
    );

    assign control   = q.control;
    assign a_sel     = q.a_sel;
    assign b_sel     = q.b_sel;
    assign imm_ext   = q.imm_ext;
    assign rs_idx    = q.rs_idx;
    assign rt_idx    = q.rt_idx;
    assign dst_idx   = q.dst_idx;
    assign reg_write = q.reg_write;
    assign illegal   = q.illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_count <= 8'd0;
        else if (in_valid && in_ready && dec.illegal && illegal_count != 8'hFF)
            illegal_count <= illegal_count + 8'd1;
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed vector table plus stall, saturation and reset sequences.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  control;
    logic        a_sel;
    logic        b_sel;
    logic [31:0] imm_ext;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  dst_idx;
    logic        reg_write;
    logic        illegal;
    logic [7:0]  illegal_count;

    int checks = 0;
    int errors = 0;

    alu_decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .control       (control),
        .a_sel         (a_sel),
        .b_sel         (b_sel),
        .imm_ext       (imm_ext),
        .rs_idx        (rs_idx),
        .rt_idx        (rt_idx),
        .dst_idx       (dst_idx),
        .reg_write     (reg_write),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  control;
        logic        a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic        rw;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        instr = w;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] words[4];
        logic [3:0]  exp_ctrl[4];
        int exp_cnt;
        int sent;
        int got;
        vecs[0]  = '{32'h012A4020, 4'd0,  1'b0, 1'b0, 32'h00004020, 5'd8, 1'b1, 1'b0};
        vecs[1]  = '{32'h2128FFFF, 4'd0,  1'b0, 1'b1, 32'hFFFFFFFF, 5'd8, 1'b1, 1'b0};
        vecs[2]  = '{32'h3508FFFF, 4'd13, 1'b0, 1'b1, 32'h0000FFFF, 5'd8, 1'b1, 1'b0};
        vecs[3]  = '{32'h00084080, 4'd7,  1'b1, 1'b0, 32'h00004080, 5'd8, 1'b1, 1'b0};
        vecs[4]  = '{32'h3C081234, 4'd14, 1'b0, 1'b1, 32'h00001234, 5'd8, 1'b1, 1'b0};
        vecs[5]  = '{32'h012A4022, 4'd1,  1'b0, 1'b0, 32'h00004022, 5'd8, 1'b1, 1'b0};
        vecs[6]  = '{32'h012A402A, 4'd9,  1'b0, 1'b0, 32'h0000402A, 5'd8, 1'b1, 1'b0};
        vecs[7]  = '{32'h012A4007, 4'd12, 1'b0, 1'b0, 32'h00004007, 5'd8, 1'b1, 1'b0};
        vecs[8]  = '{32'hAD28FFFC, 4'd2,  1'b0, 1'b1, 32'hFFFFFFFC, 5'd8, 1'b0, 1'b0};
        vecs[9]  = '{32'h1109FFFE, 4'd1,  1'b0, 1'b0, 32'hFFFFFFFE, 5'd9, 1'b0, 1'b0};
        vecs[10] = '{32'h3128F000, 4'd4,  1'b0, 1'b1, 32'h0000F000, 5'd8, 1'b1, 1'b0};
`ifdef ALU_DEC_MULDIV_EN
        vecs[11] = '{32'h01090018, 4'd10, 1'b0, 1'b0, 32'h00000018, 5'd0, 1'b0, 1'b0};
        vecs[12] = '{32'h0109001A, 4'd11, 1'b0, 1'b0, 32'h0000001A, 5'd0, 1'b0, 1'b0};
`else
        vecs[11] = '{32'h01090018, 4'd15, 1'b0, 1'b0, 32'h00000018, 5'd0, 1'b0, 1'b1};
        vecs[12] = '{32'h0109001A, 4'd15, 1'b0, 1'b0, 32'h0000001A, 5'd0, 1'b0, 1'b1};
`endif
        vecs[13] = '{32'hFC000000, 4'd15, 1'b0, 1'b0, 32'h00000000, 5'd0, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_illegal_count", illegal_count, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_control", control, 0);
        chk("rst_imm_ext", imm_ext, 0);
        chk("rst_dst_idx", dst_idx, 0);
        chk("rst_reg_write", reg_write, 0);
        rst = 1'b0;

        exp_cnt = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            send(vecs[i].instr);
            if (vecs[i].ill) exp_cnt++;
            @(negedge clk);
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_control", i), control, vecs[i].control);
            chk($sformatf("v%0d_a_sel", i), a_sel, vecs[i].a_sel);
            chk($sformatf("v%0d_b_sel", i), b_sel, vecs[i].b_sel);
            chk($sformatf("v%0d_imm_ext", i), imm_ext, vecs[i].imm);
            chk($sformatf("v%0d_dst_idx", i), dst_idx, vecs[i].dst);
            chk($sformatf("v%0d_rs_idx", i), rs_idx, vecs[i].instr[25:21]);
            chk($sformatf("v%0d_rt_idx", i), rt_idx, vecs[i].instr[20:16]);
            chk($sformatf("v%0d_reg_write", i), reg_write, vecs[i].rw);
            chk($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
        end
        @(negedge clk);
        chk("table_drained", out_valid, 0);
        chk("table_illegal_count", illegal_count, exp_cnt);

        // 300 illegal words streamed back-to-back
        sent = 0;
        got = 0;
        for (int c = 0; c < 1000 && got < 300; c++) begin
            @(negedge clk);
            if (out_valid) begin
                chk($sformatf("ill%0d_control", got), control, 15);
                chk($sformatf("ill%0d_illegal", got), illegal, 1);
                got++;
            end
            in_valid = (sent < 300);
            instr = 32'hFC000000 | sent;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        chk("ill_stream_count", got, 300);
        exp_cnt = (exp_cnt + 300 > 255) ? 255 : exp_cnt + 300;
        @(negedge clk);
        chk("ill_saturated", illegal_count, exp_cnt);

        // four words with out_ready held low for the first three cycles
        words[0] = 32'h012A4020; exp_ctrl[0] = 4'd0;
        words[1] = 32'h012A4022; exp_ctrl[1] = 4'd1;
        words[2] = 32'h3128F000; exp_ctrl[2] = 4'd4;
        words[3] = 32'h3508FFFF; exp_ctrl[3] = 4'd13;
        sent = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 3);
            if (c == 2) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_accepted", sent, 2);
            end
            if (out_valid) begin
                chk($sformatf("stall_ctrl%0d", got), control, exp_ctrl[got]);
                if (out_ready) got++;
            end
            in_valid = (sent < 4);
            instr = words[sent < 4 ? sent : 3];
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        chk("stall_received", got, 4);
        @(negedge clk);
        chk("stall_no_dup", out_valid, 0);

        // reset with both entries occupied
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        instr = 32'h012A4020;
        @(negedge clk);
        instr = 32'h012A4022;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_illegal_count", illegal_count, 0);
        chk("mid_rst_control", control, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h3C081234);
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_control", control, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Decode-side producer for the 4-bit ALU control code. It accepts MIPS instruction words over a valid/ready handshake and decodes opcode/funct into an ALU control code, operand selects and an extended immediate. Results leave through a registered output with a skid buffer. It sits between fetch and the execute stage that drives the ALU's `a`, `b` and `control` inputs.

## Interface
- `LENGTH`, 32: datapath width (instruction and immediate).
- `CONTROL_LENGTH`, 4: ALU control code width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  instruction word present.
- `in_ready`  out  1  stage can accept.
- `instr`  in  LENGTH  MIPS instruction word.
- `out_valid`  out  1  decoded bundle present.
- `out_ready`  in  1  execute stage accepts.
- `control`  out  CONTROL_LENGTH  ALU control code.
- `a_sel`  out  1  operand A source: 0 = rs register, 1 = shamt zero-extended.
- `b_sel`  out  1  operand B source: 0 = rt register, 1 = `imm_ext`.
- `imm_ext`  out  LENGTH  sign- or zero-extended imm16.
- `rs_idx`, `rt_idx`, `dst_idx`  out  5 each  register indices; `dst_idx` = rd for R-type, rt for I-type.
- `reg_write`  out  1  destination is written.
- `illegal`  out  1  instruction not decodable.
- `illegal_count`  out  8  saturating count of illegal instructions accepted.

## Operation
- Transfer occurs when valid and ready are both high in the same cycle, on input or output.
- Control code map:
  - 0 add, 1 sub, 2 addu, 3 subu, 4 and, 5 xor, 6 nor, 7 sll, 8 srl.
  - 9 slt, 10 mult, 11 div, 12 sra, 13 or, 14 lui, 15 invalid.
- R-type (opcode 0x00), decoded by funct:
  - 0x20 add, 0x22 sub, 0x21 addu, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt.
  - 0x00 sll, 0x02 srl, 0x03 sra with `a_sel`=1.
  - 0x04 sllv, 0x06 srlv, 0x07 srav map to 7/8/12 with `a_sel`=0.
  - 0x18 mult, 0x1A div.
- I-type (`b_sel`=1, `dst_idx`=rt), decoded by opcode:
  - Sign-extended imm: 0x08 addi→0, 0x09 addiu→2, 0x0A slti→9, 0x23 lw→2, 0x2B sw→2.
  - Zero-extended imm: 0x0C andi→4, 0x0D ori→13, 0x0E xori→5.
  - 0x0F lui→14 with zero-extended imm; the ALU performs the shift.
  - 0x04 beq, 0x05 bne→1 with `b_sel`=0.
- `reg_write`:
  - 0 for sw, beq, bne, mult, div and illegal instructions.
  - 1 for every other decoded instruction.
- Any other opcode/funct gives `control`=15, `illegal`=1, `reg_write`=0. The bundle still transfers normally.
- `illegal_count` increments on each accepted illegal instruction and saturates at 255.

## Timing
- Latency: one cycle from the input transfer to `out_valid`.
- Skid buffer:
  - Main register plus one skid register.
  - `in_ready` = skid register empty; it is registered and has no combinational path from `out_ready`.
- Full throughput when `out_ready` stays high.
- Stall: if `out_ready` drops while a new word is accepted, the word goes to the skid register and `in_ready` falls the next cycle.
- The skid entry drains to the main register on the next output transfer. Order is preserved.
- Simultaneous input and output transfer with the skid register empty: the main register reloads, with no bubble.
- While `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- Reset values:
  - `out_valid`=0, `in_ready`=1, `illegal_count`=0, `illegal`=0.
  - `control`=0, `a_sel`=0, `b_sel`=0, `imm_ext`=0, all indices 0, `reg_write`=0.
- Reset mid-operation discards both buffered entries immediately.

## Configuration
- `ALU_DEC_MULDIV_EN` defined: funct 0x18 and 0x1A decode to 10 and 11.
- `ALU_DEC_MULDIV_EN` undefined: funct 0x18 and 0x1A decode as illegal (`control`=15) and increment `illegal_count`.

## Structure
- Package `alu_pkg`:
  - `alu_ctrl_t` enum for codes 0–15.
  - Opcode and funct localparams.
  - `alu_dec_t` packed struct holding the decoded bundle.
- Combinational decode function in the package.
- Sub-module `skid_buffer`, parameterized by payload width, carries `alu_dec_t`.

## Test plan
- Input 0x012A4020 (add $t0,$t1,$t2) with `out_ready`=1 → one cycle later `control`=0, `dst_idx`=8, `reg_write`=1, `a_sel`=0, `b_sel`=0.
- Input 0x2128FFFF (addi) → `control`=0, `imm_ext`=0xFFFFFFFF, `b_sel`=1. Input 0x3508FFFF (ori) → `control`=13, `imm_ext`=0x0000FFFF.
- Input 0x00084080 (sll $t0,$t0,2) → `control`=7, `a_sel`=1. Input 0x3C081234 (lui) → `control`=14, `imm_ext`=0x00001234.
- Stream of 4 words with `out_ready` low for 3 cycles:
  - `in_ready` falls after 2 accepted words.
  - All 4 words emerge in order with no duplication or loss.
- 300 words with opcode 0x3F → each has `control`=15 and `illegal`=1; `illegal_count` saturates at 255.
- Assert `rst` while the skid register is full → `out_valid`=0 and `in_ready`=1 immediately. Build without `ALU_DEC_MULDIV_EN` and input funct 0x18 → `illegal`=1.
